// File: rtl/sram_port_arb.sv
`timescale 1ns/1ps
// sram_port_arb: shares one native SRAM port between r0 (AXI SRAM ctrl) and r1 (DSP engine); optional macro SRAM_ARB_FIXED_PRIO_EN.
// Latency: grant and SRAM command are combinational in the request cycle; read data returns MEM_RD_LAT cycles later.
// Backpressure: a requester that sees its gnt low must hold req/we/addr/di; tenures are capped at BURST_MAX beats when contended.
module sram_port_arb #(
   parameter int MEM_ADDRW  = 22,
   parameter int MEM_DW     = 256,
   parameter int MEM_RD_LAT = 1,
   parameter int BURST_MAX  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 r0_req,
   input  logic                 r0_we,
   input  logic [MEM_ADDRW-1:0] r0_addr,
   input  logic [MEM_DW-1:0]    r0_di,
   output logic                 r0_gnt,
   output logic                 r0_rvalid,
   output logic [MEM_DW-1:0]    r0_do,
   input  logic                 r1_req,
   input  logic                 r1_we,
   input  logic [MEM_ADDRW-1:0] r1_addr,
   input  logic [MEM_DW-1:0]    r1_di,
   output logic                 r1_gnt,
   output logic                 r1_rvalid,
   output logic [MEM_DW-1:0]    r1_do,
   output logic [MEM_ADDRW-1:0] mem_addr,
   output logic                 mem_we,
   output logic [MEM_DW-1:0]    mem_di,
   input  logic [MEM_DW-1:0]    mem_do,
   output logic [1:0]           owner,
   output logic                 busy
);

   localparam int              CNTW    = $clog2(BURST_MAX + 1);
   localparam logic [CNTW-1:0] CNT_MAX = CNTW'(BURST_MAX);
   localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_R0   = 2'b01,
      OWN_R1   = 2'b10
   } own_e;

   own_e            owner_q, owner_d;
   logic [CNTW-1:0] cnt_q, cnt_d;     // beats granted in the current tenure
   logic            last_q, last_d;   // requester served most recently, 1 = r1
   logic            win_vld;          // some requester wins this cycle (before reset gating)
   logic            win_id;           // 0 = r0, 1 = r1
   logic            own_id;
   logic            own_req;
   logic            oth_req;
   logic            gnt_vld;
   logic            rd_issue;

   // read-return pipeline: one {valid, id} per SRAM latency stage
   logic [MEM_RD_LAT-1:0] rp_vld;
   logic [MEM_RD_LAT-1:0] rp_id;

   // state register: tenure owner, beat counter, last-served pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q <= OWN_NONE;
         cnt_q   <= '0;
         last_q  <= 1'b1;
      end else begin
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
      end
   end

   // next-state: pick this cycle's winner following the tenure priority rules
   always_comb begin
      win_vld = 1'b0;
      win_id  = 1'b0;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      own_id  = (owner_q == OWN_R1);
      own_req = own_id ? r1_req : r0_req;
      oth_req = own_id ? r0_req : r1_req;

      if (owner_q != OWN_NONE) begin
         if (own_req && (cnt_q < CNT_MAX)) begin
            // tenure continues
            win_vld = 1'b1;
            win_id  = own_id;
            cnt_d   = cnt_q + CNT_ONE;
         end else if (oth_req) begin
            // owner dropped req or hit the beat limit while the other waits
            win_vld = 1'b1;
            win_id  = ~own_id;
            cnt_d   = CNT_ONE;
         end else if (own_req) begin
            // limit reached but nobody contends: reload and keep going
            win_vld = 1'b1;
            win_id  = own_id;
            cnt_d   = CNT_ONE;
         end
      end else begin
         if (r0_req && r1_req) begin
            win_vld = 1'b1;
`ifdef SRAM_ARB_FIXED_PRIO_EN
            win_id  = 1'b0;
`else
            win_id  = ~last_q;
`endif
            cnt_d   = CNT_ONE;
         end else if (r0_req) begin
            win_vld = 1'b1;
            win_id  = 1'b0;
            cnt_d   = CNT_ONE;
         end else if (r1_req) begin
            win_vld = 1'b1;
            win_id  = 1'b1;
            cnt_d   = CNT_ONE;
         end
      end

      if (win_vld) begin
         owner_d = win_id ? OWN_R1 : OWN_R0;
         last_d  = win_id;
      end else begin
         owner_d = OWN_NONE;
         cnt_d   = '0;
      end
   end

   // outputs: grants, SRAM command mux, read-return steering, status
   always_comb begin
      gnt_vld  = win_vld && !rst;
      r0_gnt   = gnt_vld && !win_id;
      r1_gnt   = gnt_vld && win_id;
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_di   = '0;
      if (r0_gnt) begin
         mem_we   = r0_we;
         mem_addr = r0_addr;
         mem_di   = r0_di;
      end else if (r1_gnt) begin
         mem_we   = r1_we;
         mem_addr = r1_addr;
         mem_di   = r1_di;
      end
      rd_issue  = gnt_vld && !mem_we;
      // reads still in flight when reset hits are dropped, including the one at the tail
      r0_rvalid = !rst && rp_vld[MEM_RD_LAT-1] && !rp_id[MEM_RD_LAT-1];
      r1_rvalid = !rst && rp_vld[MEM_RD_LAT-1] &&  rp_id[MEM_RD_LAT-1];
      owner     = owner_q;
      busy      = (owner_q != OWN_NONE) || (|rp_vld);
   end

   // both requesters see the raw SRAM data; rvalid says whose it is
   assign r0_do = mem_do;
   assign r1_do = mem_do;

   // read-return shift register, aligned with the SRAM read latency
   always_ff @(posedge clk) begin
      if (rst) begin
         rp_vld <= '0;
         rp_id  <= '0;
      end else begin
         rp_vld[0] <= rd_issue;
         rp_id[0]  <= win_id;
         for (int i = 1; i < MEM_RD_LAT; i++) begin
            rp_vld[i] <= rp_vld[i-1];
            rp_id[i]  <= rp_id[i-1];
         end
      end
   end

endmodule

// File: doc/sram_port_arb.md
# sram_port_arb

Two-requester arbiter that shares the single native SRAM port (address, write enable, write data, read data) of the DSP memory between the AXI-side SRAM controller and a local DSP engine. It grants one requester per cycle, holds the grant for bursts up to a configurable beat limit, and routes read data back to the requester that issued each read. It sits between the requesters and the SRAM macro, in place of a direct point-to-point connection.

## Interface
- MEM_ADDRW, 22, SRAM word address width
- MEM_DW, 256, SRAM data width
- MEM_RD_LAT, 1, SRAM read latency in cycles (≥1)
- BURST_MAX, 16, max consecutive beats in one tenure before a waiting requester preempts (≥1)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- r0_req, r1_req  in  1  access request, one per beat
- r0_we, r1_we  in  1  1 = write, 0 = read
- r0_addr, r1_addr  in  MEM_ADDRW  word address
- r0_di, r1_di  in  MEM_DW  write data
- r0_gnt, r1_gnt  out  1  beat accepted this cycle (combinational)
- r0_rvalid, r1_rvalid  out  1  read data valid for that requester
- r0_do, r1_do  out  MEM_DW  read data (both driven from mem_do)
- mem_addr  out  MEM_ADDRW  SRAM address
- mem_we  out  1  SRAM write enable
- mem_di  out  MEM_DW  SRAM write data
- mem_do  in  MEM_DW  SRAM read data
- owner  out  2  current tenure: 2'b00 none, 2'b01 r0, 2'b10 r1
- busy  out  1  owner ≠ none or read pipeline non-empty

## Operation
- Beat: cycle with rX_req && rX_gnt. At most one gnt high per cycle.
- State: owner (NONE/OWN0/OWN1), beat counter cnt (1..BURST_MAX), last-served pointer last (reset = r1).
- Per-cycle decision, in priority order:
  - owner's req high and cnt < BURST_MAX → grant owner, cnt+1.
  - other requester's req high → switch, grant other, cnt = 1, last = other.
  - owner's req high (limit hit, no contender) → grant owner, cnt = 1.
  - owner NONE, both requesting → arbitration rule (see Configuration); single requester wins directly.
  - no req → owner = NONE, no grant.
- A tenure ends the first cycle its owner drops req; owner becomes NONE or switches in that same cycle.
- Granted beat drives mem_addr/mem_we/mem_di from the winner; no grant → mem_we = 0, mem_addr = 0, mem_di = 0.
- Read return: shift register of MEM_RD_LAT stages {valid, id}; stage 0 loaded with {granted && !we, winner}. Tail valid asserts rX_rvalid for the tagged id; rX_do = mem_do combinationally.
- Reads and writes to the same address in consecutive beats are ordered by grant order; no forwarding.

## Timing
- Reset values: r0_gnt = r1_gnt = 0, mem_we = 0, mem_addr = 0, mem_di = 0, rX_rvalid = 0, owner = 00, busy = 0, cnt = 0, last = r1.
- rst high forces all gnt and mem_we to 0 in the same cycle; read pipeline flushed, in-flight reads discarded (no rvalid).
- gnt is combinational from req and registered state; requesters must not derive req combinationally from gnt.
- Read issued at cycle T returns rvalid at T+MEM_RD_LAT; full throughput, one beat per cycle, no bubble on owner switch.
- Simultaneous request with cnt = BURST_MAX: switch happens on beat BURST_MAX+1; the owner sees gnt low that cycle and must hold req/addr/data.
- cnt never exceeds BURST_MAX; wrap handled by reload to 1.

## Configuration
- SRAM_ARB_FIXED_PRIO_EN defined: when owner is NONE and both request, r0 always wins; BURST_MAX preemption still applies to both, so r1 is guaranteed a slot after each r0 tenure of BURST_MAX beats.
- Undefined: round-robin; when owner is NONE and both request, the requester ≠ last wins (r0 first after reset).

## Test plan
- Single r0 writes addr 0x10..0x13, data 0xA0..0xA3, then reads them → gnt every cycle, mem_we 1 for 4 cycles, r0_rvalid at T+MEM_RD_LAT with 0xA0..0xA3, r1_rvalid never high.
- Both req from idle, continuous, BURST_MAX=16 → r0 gets 16 beats, r1 16 beats, alternating; owner toggles 01/10; no cycle without gnt.
- r1 alone streams 40 reads → 40 consecutive grants, cnt reloads at 17th beat, no stall; 40 r1_rvalid.
- Interleaved reads r0 addr 0x5 and r1 addr 0x6 in adjacent cycles (after preemption) → each rvalid arrives on the correct requester with its own data.
- rst asserted one cycle after 3 reads granted, MEM_RD_LAT=2 → no rvalid afterwards, outputs at reset values, next request granted normally.
- With SRAM_ARB_FIXED_PRIO_EN, both req from idle after r0 served last → r0 wins; without macro → r1 wins.
